// File: rtl/tcb_pkg.sv
// Shared TCB bus definitions used by the R5P memory subordinate.
// Contents:
//   tcb_siz_t   - log2 transfer size encoding (BYTE, HALF, WORD, RSVD)
//   tcb_byt     - byte-lane mask of an access on a 32-bit bus
//   tcb_aligned - natural alignment check of an access
package tcb_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2,
    RSVD = 2'd3
  } tcb_siz_t;

  // Lane mask ((1 << (1 << siz)) - 1) << adr, truncated to the 4 byte lanes.
  // RSVD yields an 8-lane run, so after truncation it touches every lane
  // from the start address upwards.
  function automatic logic [3:0] tcb_byt(input logic [1:0] adr, input tcb_siz_t siz);
    logic [10:0] msk;
    case (siz)
      BYTE:    msk = 11'h001;
      HALF:    msk = 11'h003;
      WORD:    msk = 11'h00f;
      default: msk = 11'h0ff;
    endcase
    msk = msk << adr;
    return msk[3:0];
  endfunction

  // An access is aligned when adr % (1 << siz) == 0; RSVD is never aligned.
  function automatic logic tcb_aligned(input logic [1:0] adr, input tcb_siz_t siz);
    logic ok;
    case (siz)
      BYTE:    ok = 1'b1;
      HALF:    ok = ~adr[0];
      WORD:    ok = (adr == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/r5p_tcb_mem_pipe.sv
// Fixed-latency response pipeline of the TCB memory subordinate.
// Each stage carries {vld, rdt, err}; the last stage is the bus response.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-low reset, clears every stage
//   in_vld  - a response enters stage 1 this cycle
//   in_rdt  - word read from the array for that response
//   in_err  - error flag for that response
//   out_rdt - last stage data, holds its value between responses
//   out_err - error flag, asserted for the cycle the response is presented
module r5p_tcb_mem_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned DLY  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  input  logic [XLEN-1:0] in_rdt,
  input  logic            in_err,
  output logic [XLEN-1:0] out_rdt,
  output logic            out_err
);

  logic [DLY-1:0]  vld_q, vld_d;
  logic [DLY-1:0]  err_q, err_d;
  logic [XLEN-1:0] rdt_q [DLY];
  logic [XLEN-1:0] rdt_d [DLY];

  // Data registers only load when a response moves into them, so the
  // final stage keeps the previous read data while idle.
  always_comb begin
    vld_d[0] = in_vld;
    err_d[0] = in_vld & in_err;
    rdt_d[0] = in_vld ? in_rdt : rdt_q[0];
    for (int i = 1; i < DLY; i++) begin
      vld_d[i] = vld_q[i-1];
      err_d[i] = err_q[i-1];
      rdt_d[i] = vld_q[i-1] ? rdt_q[i-1] : rdt_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < DLY; i++) begin
        rdt_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      rdt_q <= rdt_d;
    end
  end

  assign out_rdt = rdt_q[DLY-1];
  assign out_err = vld_q[DLY-1] & err_q[DLY-1];

endmodule

// File: rtl/r5p_tcb_mem_sub.sv
// TCB subordinate memory: byte-lane writes, WAIT wait states per request
// and a DLY-cycle read response pipeline.
// Optional feature: define R5P_TCB_MEM_SUB_ERR_EN to block misaligned
// writes and report them (and misaligned reads) on tcb_err.
// Ports:
//   clk, rst             - clock (rising edge), asynchronous active-low reset
//   tcb_vld / tcb_rdy    - request handshake, transfer when both are high
//   tcb_wen / tcb_ren    - write / read enable
//   tcb_adr / tcb_siz    - byte address / log2 transfer size
//   tcb_wdt              - write data on natural byte lanes
//   tcb_rdt / tcb_err    - read data / error, DLY cycles after the transfer
module r5p_tcb_mem_sub
  import tcb_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SIZE = 4096,
  parameter int unsigned DLY  = 1,
  parameter int unsigned WAIT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tcb_vld,
  output logic            tcb_rdy,
  input  logic            tcb_wen,
  input  logic            tcb_ren,
  input  logic [XLEN-1:0] tcb_adr,
  input  logic [1:0]      tcb_siz,
  input  logic [XLEN-1:0] tcb_wdt,
  output logic [XLEN-1:0] tcb_rdt,
  output logic            tcb_err
);

  localparam int unsigned AW    = $clog2(SIZE);
  localparam int unsigned DEPTH = SIZE / 4;
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

  logic [3:0]      cnt_q, cnt_d;
  logic            trn;
  logic [AW-3:0]   idx;
  logic [3:0]      byt;
  logic [3:0]      wr_byt;
  logic            acc_err;
  logic [XLEN-1:0] rd_word;
  logic            unused_adr;

  logic [XLEN-1:0] mem_q [DEPTH];

  assign trn        = tcb_vld & tcb_rdy;
  assign idx        = tcb_adr[AW-1:2];
  assign unused_adr = ^tcb_adr[XLEN-1:AW];
  assign byt        = tcb_byt(tcb_adr[1:0], tcb_siz_t'(tcb_siz));
  assign rd_word    = mem_q[idx];

`ifdef R5P_TCB_MEM_SUB_ERR_EN
  // Misaligned or reserved-size accesses write nothing and flag an error.
  assign acc_err = ~tcb_aligned(tcb_adr[1:0], tcb_siz_t'(tcb_siz));
`else
  assign acc_err = 1'b0;
`endif

  // Lanes actually written this cycle.
  always_comb begin
    wr_byt = '0;
    if (trn && tcb_wen && !acc_err) begin
      wr_byt = byt;
    end
  end

  // Wait-state counter: counts stalled cycles up to WAIT, clears on
  // transfer and holds when the manager withdraws the request.
  always_comb begin
    cnt_d = cnt_q;
    if (trn) begin
      cnt_d = '0;
    end else if (tcb_vld && !tcb_rdy) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tcb_rdy = (cnt_q == WAIT_CNT);

  // Memory array is not reset; contents survive a reset pulse.
  // The stage-1 capture of rd_word happens on the same edge as the write,
  // so a combined read/write returns the old word.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_byt[b]) begin
        mem_q[idx][8*b +: 8] <= tcb_wdt[8*b +: 8];
      end
    end
  end

  // Errored writes also enter the pipeline so the error lines up with DLY.
  r5p_tcb_mem_pipe #(
    .XLEN (XLEN),
    .DLY  (DLY)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (trn & (tcb_ren | acc_err)),
    .in_rdt  (rd_word),
    .in_err  (acc_err),
    .out_rdt (tcb_rdt),
    .out_err (tcb_err)
  );

endmodule

// File: tb/tb_r5p_tcb_mem_sub.sv
// Directed bench for r5p_tcb_mem_sub with three instances:
//   u0 WAIT=0 DLY=1, u1 WAIT=2 DLY=3, u2 WAIT=0 DLY=2.
module tb_r5p_tcb_mem_sub;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        vld0, vld1, vld2;
  logic        wen, ren;
  logic [31:0] adr, wdt;
  logic [1:0]  siz;
  logic        rdy0, rdy1, rdy2;
  logic [31:0] rdt0, rdt1, rdt2;
  logic        err0, err1, err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  r5p_tcb_mem_sub #(.XLEN(32), .SIZE(4096), .DLY(1), .WAIT(0)) u0 (
    .clk(clk), .rst(rst_a), .tcb_vld(vld0), .tcb_rdy(rdy0), .tcb_wen(wen), .tcb_ren(ren),
    .tcb_adr(adr), .tcb_siz(siz), .tcb_wdt(wdt), .tcb_rdt(rdt0), .tcb_err(err0));

  r5p_tcb_mem_sub #(.XLEN(32), .SIZE(4096), .DLY(3), .WAIT(2)) u1 (
    .clk(clk), .rst(rst_a), .tcb_vld(vld1), .tcb_rdy(rdy1), .tcb_wen(wen), .tcb_ren(ren),
    .tcb_adr(adr), .tcb_siz(siz), .tcb_wdt(wdt), .tcb_rdt(rdt1), .tcb_err(err1));

  r5p_tcb_mem_sub #(.XLEN(32), .SIZE(4096), .DLY(2), .WAIT(0)) u2 (
    .clk(clk), .rst(rst_b), .tcb_vld(vld2), .tcb_rdy(rdy2), .tcb_wen(wen), .tcb_ren(ren),
    .tcb_adr(adr), .tcb_siz(siz), .tcb_wdt(wdt), .tcb_rdt(rdt2), .tcb_err(err2));

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic rdy_of(input int k);
    case (k)
      0:       return rdy0;
      1:       return rdy1;
      default: return rdy2;
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic applyStimulus(input int k, input logic w, input logic r,
                               input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    bit done = 1'b0;
    wen = w; ren = r; adr = a; siz = s; wdt = d;
    case (k)
      0:       vld0 = 1'b1;
      1:       vld1 = 1'b1;
      default: vld2 = 1'b1;
    endcase
    for (int n = 0; n < 32 && !done; n++) begin
      if (rdy_of(k)) done = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    vld0 = 1'b0; vld1 = 1'b0; vld2 = 1'b0; wen = 1'b0; ren = 1'b0;
    checkOutput("xfer_accepted", {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    vld0 = 1'b0; vld1 = 1'b0; vld2 = 1'b0;
    wen = 1'b0; ren = 1'b0; adr = '0; siz = 2'd2; wdt = '0;

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    checkOutput("rst_rdy0", {31'd0, rdy0}, 32'd1);
    checkOutput("rst_rdt0", rdt0, 32'd0);
    checkOutput("rst_err0", {31'd0, err0}, 32'd0);
    checkOutput("rst_rdy1", {31'd0, rdy1}, 32'd0);
    checkOutput("rst_rdt1", rdt1, 32'd0);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_rdy0", {31'd0, rdy0}, 32'd1);

    // Word then bytes / halves
    applyStimulus(0, 1, 0, 32'h10, 2'd2, 32'hDEADBEEF);
    applyStimulus(0, 0, 1, 32'h10, 2'd2, 32'h0);
    checkOutput("word_rd", rdt0, 32'hDEADBEEF);
    checkOutput("word_err", {31'd0, err0}, 32'd0);
    applyStimulus(0, 1, 0, 32'h12, 2'd0, 32'h00550000);
    applyStimulus(0, 0, 1, 32'h10, 2'd2, 32'h0);
    checkOutput("byte_rd", rdt0, 32'hDE55BEEF);
    applyStimulus(0, 1, 0, 32'h12, 2'd1, 32'hABCD0000);
    applyStimulus(0, 0, 1, 32'h10, 2'd2, 32'h0);
    checkOutput("half_rd", rdt0, 32'hABCDBEEF);

    // Wrap-around, and read data holds across a write
    applyStimulus(0, 1, 0, 32'h1004, 2'd2, 32'h12345678);
    checkOutput("rdt_hold", rdt0, 32'hABCDBEEF);
    applyStimulus(0, 0, 1, 32'h0004, 2'd2, 32'h0);
    checkOutput("wrap_rd", rdt0, 32'h12345678);

    // Combined read+write returns old data, then new
    applyStimulus(0, 1, 1, 32'h10, 2'd2, 32'h11112222);
    checkOutput("rw_old", rdt0, 32'hABCDBEEF);
    applyStimulus(0, 0, 1, 32'h10, 2'd2, 32'h0);
    checkOutput("rw_new", rdt0, 32'h11112222);

    // Misaligned half-word write at 0x21
    applyStimulus(0, 1, 0, 32'h20, 2'd2, 32'hCAFEF00D);
    applyStimulus(0, 1, 0, 32'h21, 2'd1, 32'h0000FFFF);
`ifdef R5P_TCB_MEM_SUB_ERR_EN
    checkOutput("mis_err", {31'd0, err0}, 32'd1);
    checkOutput("mis_rdt", rdt0, 32'hCAFEF00D);
    applyStimulus(0, 0, 1, 32'h20, 2'd2, 32'h0);
    checkOutput("mis_keep", rdt0, 32'hCAFEF00D);
    checkOutput("mis_err_clr", {31'd0, err0}, 32'd0);
    applyStimulus(0, 1, 0, 32'h20, 2'd3, 32'h0);
    checkOutput("rsvd_err", {31'd0, err0}, 32'd1);
    applyStimulus(0, 0, 1, 32'h20, 2'd2, 32'h0);
    checkOutput("rsvd_keep", rdt0, 32'hCAFEF00D);
`else
    checkOutput("mis_err", {31'd0, err0}, 32'd0);
    checkOutput("mis_rdt", rdt0, 32'h11112222);
    applyStimulus(0, 0, 1, 32'h20, 2'd2, 32'h0);
    checkOutput("mis_lanes", rdt0, 32'hCA00FF0D);
`endif

    // Wait states and latency on u1 (WAIT=2, DLY=3)
    applyStimulus(1, 1, 0, 32'h0, 2'd2, 32'hA5A50001);
    checkOutput("ws_wr_rdt", rdt1, 32'd0);
    ren = 1'b1; adr = 32'h0; siz = 2'd2; vld1 = 1'b1;
    checkOutput("ws_rdy_c0", {31'd0, rdy1}, 32'd0);
    @(negedge clk);
    checkOutput("ws_rdy_c1", {31'd0, rdy1}, 32'd0);
    @(negedge clk);
    checkOutput("ws_rdy_c2", {31'd1 & 31'd0, rdy1}, 32'd1);
    @(negedge clk);
    vld1 = 1'b0; ren = 1'b0;
    checkOutput("ws_cnt_clr", {31'd0, rdy1}, 32'd0);
    checkOutput("lat_e1", rdt1, 32'd0);
    @(negedge clk);
    checkOutput("lat_e2", rdt1, 32'd0);
    @(negedge clk);
    checkOutput("lat_e3", rdt1, 32'hA5A50001);

    // Back-to-back reads on u2 (WAIT=0, DLY=2)
    applyStimulus(2, 1, 0, 32'h0, 2'd2, 32'h10000000);
    applyStimulus(2, 1, 0, 32'h4, 2'd2, 32'h10000004);
    applyStimulus(2, 1, 0, 32'h8, 2'd2, 32'h10000008);
    ren = 1'b1; siz = 2'd2; adr = 32'h0; vld2 = 1'b1;
    @(negedge clk);
    adr = 32'h4;
    checkOutput("b2b_idle", rdt2, 32'd0);
    @(negedge clk);
    adr = 32'h8;
    checkOutput("b2b_0", rdt2, 32'h10000000);
    @(negedge clk);
    vld2 = 1'b0; ren = 1'b0;
    checkOutput("b2b_1", rdt2, 32'h10000004);
    @(negedge clk);
    checkOutput("b2b_2", rdt2, 32'h10000008);

    // Reset with a read in flight
    ren = 1'b1; adr = 32'h0; vld2 = 1'b1;
    @(negedge clk);
    vld2 = 1'b0; ren = 1'b0;
    rst_b = 1'b0;
    #1;
    checkOutput("midrst_rdt", rdt2, 32'd0);
    rst_b = 1'b1;
    @(negedge clk);
    checkOutput("midrst_e1", rdt2, 32'd0);
    @(negedge clk);
    checkOutput("midrst_e2", rdt2, 32'd0);
    checkOutput("midrst_rdy", {31'd0, rdy2}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/r5p_tcb_mem_sub.md
# r5p_tcb_mem_sub

Synthesizable TCB subordinate memory with byte-lane writes, a configurable wait-state handshake and a fixed-latency read response pipeline. It is the responder end of the TCB IFU/LSU busses driven by the R5P cores: it accepts the requests that the degu trace monitor observes and returns the read data that the monitor samples. It serves as the instruction/data RAM of the degu SoC and as a protocol-exact bus model in benches.

## Interface
- `XLEN`, 32: data bus width in bits; only 32 supported (4 byte lanes).
- `SIZE`, 4096: memory size in bytes; power of two.
- `DLY`, 1: read response latency in cycles after transfer; range 1..4.
- `WAIT`, 0: wait states, i.e. cycles `tcb_rdy` stays low per request; range 0..15.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `tcb_vld`  in  1  request valid.
- `tcb_rdy`  out  1  request ready; transfer `trn = tcb_vld & tcb_rdy`.
- `tcb_wen`  in  1  write enable.
- `tcb_ren`  in  1  read enable.
- `tcb_adr`  in  XLEN  byte address.
- `tcb_siz`  in  2  log2 transfer size: 0 byte, 1 half, 2 word; 3 is reserved.
- `tcb_wdt`  in  XLEN  write data on natural byte lanes.
- `tcb_rdt`  out  XLEN  read data on natural byte lanes.
- `tcb_err`  out  1  response error, aligned with `tcb_rdt`.

## Operation
- Address: uses `tcb_adr[$clog2(SIZE)-1:0]`. Upper bits are ignored, so accesses above `SIZE` wrap around.
- Lane mask: `byt = ((1<<(1<<siz))-1) << adr[1:0]`. Data sits on its natural lanes and is never shifted.
- Write: on `trn & tcb_wen`, lanes in `byt` are written at the clock edge. Lanes outside `byt` are unchanged.
- Read: on `trn & tcb_ren`, the whole word is read synchronously into stage 1.
  - Stages 2..DLY are plain registers.
  - `tcb_rdt` is the last stage. It updates only when that stage carries a read, otherwise it holds its value.
- Both `wen` and `ren` set: the read returns the old data and the write is then performed.
- Wait-state counter `cnt` (0..WAIT):
  - `tcb_rdy = (cnt == WAIT)`.
  - `cnt` increments while `tcb_vld & ~tcb_rdy`.
  - `cnt` clears to 0 on `trn`.
  - `cnt` holds if `vld` drops before transfer.
- With `WAIT=0`, `tcb_rdy` is constantly 1 and back-to-back transfers are accepted every cycle.
- Read-after-write to the same address in the next cycle returns the newly written data.

## Timing
- Reset values:
  - `tcb_rdy` = (WAIT==0).
  - `tcb_rdt` = 0, `tcb_err` = 0.
  - `cnt` = 0, all pipeline valid bits 0.
  - Memory contents are not reset.
- Read latency: `tcb_rdt`/`tcb_err` are valid exactly DLY rising edges after the `trn` cycle.
- Throughput: one transfer per WAIT+1 cycles under continuous `vld`.
- Reset asserted mid-operation: in-flight pipeline stages are discarded and `cnt` clears. Writes already performed remain.
- `tcb_siz=3`: treated as misaligned (see Configuration).

## Configuration
- `R5P_TCB_MEM_SUB_ERR_EN` defined:
  - An access with `adr % (1<<siz) != 0`, or with `siz==3`, performs no write.
  - The read data of such an access is still the full word.
  - `tcb_err=1` is returned with the DLY-aligned response, for reads and for writes alike.
- `R5P_TCB_MEM_SUB_ERR_EN` not defined:
  - `tcb_err` is tied to 0.
  - Misaligned writes use the computed lane mask truncated to 4 bits; no error is reported.

## Structure
- Shared package `tcb_pkg` holds:
  - size encoding typedef `tcb_siz_t` (BYTE, HALF, WORD, RSVD);
  - lane-mask function `tcb_byt(adr, siz)`;
  - alignment check function `tcb_aligned(adr, siz)`.
- Natural sub-module: `r5p_tcb_mem_pipe`, the DLY-stage response shift register carrying {vld, rdt, err}, parameterized by DLY.
- Memory array and wait-state counter stay in the top module.

## Test plan
- Reset:
  - stimulus: WAIT=0, DLY=1, hold `rst`=0 for 3 cycles;
  - response: `tcb_rdy`=1, `tcb_rdt`=0, `tcb_err`=0.
- Word then bytes:
  - stimulus: write word 0xDEADBEEF at 0x10, then read 0x10;
  - response: `tcb_rdt`=0xDEADBEEF one cycle after the read `trn`.
  - stimulus: write byte 0x55 at 0x12 (wdt=0x00550000), then read 0x10;
  - response: `tcb_rdt`=0xDE55BEEF.
- Wait states and latency:
  - stimulus: WAIT=2, DLY=3, `vld` held high with read at 0x0;
  - response: `tcb_rdy` low for 2 cycles, high on the 3rd; data appears 3 edges after `trn`; `cnt` back to 0.
- Wrap-around:
  - stimulus: SIZE=4096, write 0x12345678 at 0x1004, then read 0x0004;
  - response: `tcb_rdt`=0x12345678.
- Misaligned (macro defined):
  - stimulus: half-word write at 0x21 with wdt=0xFFFF;
  - response: `tcb_err`=1 one cycle later (DLY=1), and a subsequent read of 0x20 shows the previous contents.
- Back-to-back:
  - stimulus: WAIT=0, DLY=2, reads at 0x0, 0x4, 0x8 on consecutive cycles;
  - response: three consecutive `tcb_rdt` values in order starting 2 cycles after the first `trn`; a reset mid-stream yields no further updates.
